// File: rtl/mac_pkg.sv
// Shared types and the requantization helper for the MAC drain path.
// The helper works at a fixed maximum width; callers pass their actual widths.
package mac_pkg;

    localparam int MAX_ACC_WIDTH   = 64;
    localparam int MAX_OUT_WIDTH   = 32;
    localparam int WIDE_WIDTH      = MAX_ACC_WIDTH + 1;
    localparam int SAT_COUNT_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    typedef struct packed {
        logic [MAX_OUT_WIDTH-1:0] data;
        logic                     sat;
    } requant_t;

    // Round-half-up right shift then unsigned saturation to out_w bits.
    // The extra top bit keeps the rounding carry; shifts at or beyond acc_w
    // collapse to 0 or 1 without special casing.
    function automatic requant_t requant(input logic [MAX_ACC_WIDTH-1:0] v,
                                         input int unsigned             s,
                                         input int unsigned             acc_w,
                                         input int unsigned             out_w);
        logic [WIDE_WIDTH-1:0] wide;
        logic [WIDE_WIDTH-1:0] rnd;
        logic [WIDE_WIDTH-1:0] r;
        logic [WIDE_WIDTH-1:0] lim;
        requant_t              res;
        wide = {1'b0, v} & ((WIDE_WIDTH'(1) << acc_w) - WIDE_WIDTH'(1));
        if (s == 0) begin
            r = wide;
        end else begin
            rnd = WIDE_WIDTH'(1) << (s - 1);
            r   = (wide + rnd) >> s;
        end
        lim      = (WIDE_WIDTH'(1) << out_w) - WIDE_WIDTH'(1);
        res.sat  = (r > lim);
        res.data = res.sat ? lim[MAX_OUT_WIDTH-1:0] : r[MAX_OUT_WIDTH-1:0];
        return res;
    endfunction

endpackage

// File: rtl/requant_unit.sv
// Purpose: combinational rounding right-shift plus unsigned saturation of one accumulator.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module requant_unit
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [ACC_WIDTH-1:0]   v,
    input  logic [SHIFT_WIDTH-1:0] s,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   saturated
);

    requant_t q;
    logic     unused_data_hi;

    always_comb begin
        q = requant(MAX_ACC_WIDTH'(v), 32'(s), ACC_WIDTH, OUT_WIDTH);
    end

    assign out_data       = q.data[OUT_WIDTH-1:0];
    assign saturated      = q.sat;
    assign unused_data_hi = ^q.data;

endmodule

// File: rtl/mac_requant_drain.sv
// Purpose: snapshot NUM_MACS accumulators on start, pulse mac_clear, stream requantized results.
// Latency: first result one cycle after start; one result per cycle while out_ready is high.
// Backpressure: out_ready low holds out_data/out_index/out_last; MAC_REQUANT_SAT_COUNT_EN adds sat_count.
module mac_requant_drain
    import mac_pkg::*;
#(
    parameter int NUM_MACS    = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    input  logic [NUM_MACS*ACC_WIDTH-1:0] acc_in,
    output logic                          mac_clear,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_MACS)-1:0]   out_index,
`ifdef MAC_REQUANT_SAT_COUNT_EN
    output logic [SAT_COUNT_WIDTH-1:0]    sat_count,
`endif
    output logic                          out_last
);

    localparam int IDX_W = $clog2(NUM_MACS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MACS - 1);

    drain_state_t            state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [ACC_WIDTH-1:0]    cap [NUM_MACS];
    logic [SHIFT_WIDTH-1:0]  shift_q;
    logic                    mac_clear_q;
    logic                    capture;
    logic                    xfer;
    logic                    at_last;
    logic [OUT_WIDTH-1:0]    rq_data;
    logic                    rq_sat;

    assign capture = (state == IDLE) && start;
    assign xfer    = (state == DRAIN) && out_ready;
    assign at_last = (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRAIN;
                    idx_nxt   = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            mac_clear_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            mac_clear_q <= capture;
        end
    end

    // Snapshot storage needs no reset; it is only read while in DRAIN.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_MACS; i++) begin
                cap[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
            end
            shift_q <= shift;
        end
    end

    requant_unit #(
        .ACC_WIDTH   (ACC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .v         (cap[idx]),
        .s         (shift_q),
        .out_data  (rq_data),
        .saturated (rq_sat)
    );

    assign busy      = (state == DRAIN);
    assign out_valid = busy;
    assign out_last  = busy && at_last;
    assign out_index = idx;
    assign out_data  = busy ? rq_data : '0;
    assign mac_clear = mac_clear_q;

`ifdef MAC_REQUANT_SAT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
        end else if (xfer && rq_sat && (sat_count != {SAT_COUNT_WIDTH{1'b1}})) begin
            sat_count <= sat_count + SAT_COUNT_WIDTH'(1);
        end
    end
`else
    logic unused_sat;
    assign unused_sat = rq_sat ^ xfer;
`endif

endmodule

// File: doc/mac_requant_drain.md
Name: mac_requant_drain

Overview:
Downstream drain stage for a row of Mac accumulators. On a start pulse it snapshots all NUM_MACS unsigned accumulator values and the shift setting, then pulses mac_clear so the array can restart. It then streams one requantized OUT_WIDTH result per element over a valid/ready interface to the output buffer/writeback. Requantization is a rounding right-shift followed by unsigned saturation.

Parameters:
NUM_MACS, 4, number of accumulators drained per snapshot (>=2)
ACC_WIDTH, 32, accumulator width (matches Mac ACC_WIDTH)
OUT_WIDTH, 8, requantized output width
SHIFT_WIDTH, 5, width of shift-amount input

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  capture request pulse; honoured only in IDLE
shift  input  SHIFT_WIDTH  right-shift amount, sampled with start
acc_in  input  NUM_MACS*ACC_WIDTH  accumulators; element i at bits [i*ACC_WIDTH +: ACC_WIDTH]
mac_clear  output  1  one-cycle pulse to Mac reset after capture
busy  output  1  high while in DRAIN
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  OUT_WIDTH  requantized result
out_index  output  clog2(NUM_MACS)  element index of out_data
out_last  output  1  high with the final element of a snapshot

Behaviour:
- Reset is synchronous and active-high on clk. After reset: state IDLE; out_valid, busy, mac_clear and out_last are 0; out_index is 0; out_data is 0; capture buffer contents are don't-care.
- FSM states: IDLE, DRAIN.
- IDLE to DRAIN: in cycle t with start=1, latch all acc_in elements into the capture buffer and latch shift. At t+1: state is DRAIN, busy=1, out_valid=1, out_index=0, mac_clear=1 for exactly that one cycle.
- In DRAIN, out_valid stays 1. A transfer occurs when out_valid and out_ready are both 1.
  - On a transfer with idx < NUM_MACS-1: idx increments.
  - On a transfer with idx = NUM_MACS-1: return to IDLE next cycle and clear idx to 0.
- out_last = (state==DRAIN) && (idx==NUM_MACS-1).
- Backpressure: while out_ready=0, out_data, out_index and out_last hold stable. No advance.
- start in DRAIN is ignored. It is not queued.
- start in the same cycle as the final transfer is ignored; the block re-arms in IDLE.
- acc_in changes after capture have no effect on the current drain.
- Requantization, combinational from the buffered value v and latched shift s:
  - s==0: r = v.
  - s>0: r = (v + 2^(s-1)) >> s, computed at ACC_WIDTH+1 bits so no carry is lost (round half up).
  - s >= ACC_WIDTH: r = (v >= 2^(ACC_WIDTH-1) && s==ACC_WIDTH) ? 1 : 0. This falls out of the wide computation.
  - Saturation: out_data = (r > 2^OUT_WIDTH-1) ? 2^OUT_WIDTH-1 : r[OUT_WIDTH-1:0].
- Throughput: NUM_MACS transfers in NUM_MACS consecutive cycles when out_ready is held high. Minimum start-to-start spacing is NUM_MACS+1 cycles.
- Reset mid-DRAIN: IDLE next cycle, out_valid=0, and any mac_clear pulse is suppressed.

Optional Feature:
Macro MAC_REQUANT_SAT_COUNT_EN.
- Defined: adds output port sat_count [15:0]. It counts transfers whose result saturated. It sticks at 16'hFFFF and clears only on reset.
- Undefined: the port and its logic are absent; the behaviour is otherwise identical.

Decomposition:
- Package mac_pkg:
  - drain state enum (IDLE, DRAIN)
  - localparam SAT_COUNT_WIDTH=16
  - function requant(v, s) parameterized by ACC_WIDTH/OUT_WIDTH, also reused by the bench model
- Sub-module requant_unit: purely combinational, v and s in, out_data and a saturated flag out. Instantiated once on the muxed buffer element.
- FSM, capture buffer and index logic stay in mac_requant_drain.

Test Plan:
- Reset: assert reset 2 cycles with start=1 -> out_valid=0, busy=0, mac_clear=0, out_index=0 throughout and after.
- Basic drain: shift=0, acc={10,20,30,40}, start at t, out_ready=1 ->
  - out_data 10,20,30,40 at t+1..t+4
  - out_last only at t+4, mac_clear only at t+1
  - busy=0 at t+5
- Rounding/saturation: shift=4, acc={24,23,8,5000} -> out_data 2,1,1,255.
  - Also shift=0, acc=255 -> 255; acc=256 -> 255.
- Backpressure: out_ready=0 at t+2..t+4 -> element 1 held stable with index 1 for 4 cycles; full sequence still correct, completing at t+7.
- Ignored start, acc change, and reset mid-drain:
  - start during DRAIN and acc_in changed after capture -> stream is unchanged.
  - reset at t+2 -> out_valid=0 at t+3.
  - A new start then drains fresh values.
- MAC_REQUANT_SAT_COUNT_EN: shift=0, acc={300,5,999,256} drained -> sat_count=3. A second identical snapshot -> sat_count=6.
